// File: rtl/interrupt_mode_controller.sv
// -----------------------------------------------------------------------------
// interrupt_mode_controller
//
// Purpose:
//   Holds the interrupt mode (IM 0/1/2), the IFF1/IFF2 enable flip-flops and
//   the EI shadow.  Edge-detects NMI, arbitrates NMI/INT at instruction
//   boundaries, runs the interrupt-acknowledge handshake and emits a resolved
//   vector to the sequencer.
//
// Ports:
//   clk, notReset        clock / asynchronous active-low reset
//   im_set, im_sel       IM instruction strobe and its mode field
//   ei, di, retn         enable-flag strobes
//   insn_end             instruction boundary (only point of acceptance)
//   int_req, nmi_req     maskable level request / non-maskable edge request
//   ack_ready, data_in   acknowledge data handshake from the device
//   i_reg                I register (IM2 table page)
//   take_irq             pulse: next fetch replaced by interrupt sequence
//   ack_req              acknowledge cycle active
//   vec_valid            pulse: vec_kind/vec_addr/opcode_out valid
//   vec_kind             0 jump, 1 indirect via table, 2 execute opcode_out
//   vec_addr, opcode_out resolved vector / IM0 opcode (held between pulses)
//   im_mode, iff1, iff2  architectural interrupt state
//   busy                 controller not idle
//
// ADDR_W must equal 2*DATA_W (IM2 vector is {i_reg, data_in}).
// -----------------------------------------------------------------------------
module interrupt_mode_controller #(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] IM1_VECTOR = 16'h0038,
   parameter logic [ADDR_W-1:0] NMI_VECTOR = 16'h0066,
   parameter int                ACK_WAIT   = 2,
   parameter bit                IM2_ALIGN  = 1'b0
) (
   input  logic              clk,
   input  logic              notReset,
   input  logic              im_set,
   input  logic [1:0]        im_sel,
   input  logic              ei,
   input  logic              di,
   input  logic              retn,
   input  logic              insn_end,
   input  logic              int_req,
   input  logic              nmi_req,
   input  logic              ack_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] i_reg,
   output logic              take_irq,
   output logic              ack_req,
   output logic              vec_valid,
   output logic [1:0]        vec_kind,
   output logic [ADDR_W-1:0] vec_addr,
   output logic [DATA_W-1:0] opcode_out,
   output logic [1:0]        im_mode,
   output logic              iff1,
   output logic              iff2,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_VEC  = 2'd2,
      ST_NMI  = 2'd3
   } state_t;

   localparam logic [3:0] ACK_WAIT_C = 4'(ACK_WAIT);

   // Map the IM opcode field onto a mode number: 0x->0, 10->1, 11->2.
   function automatic logic [1:0] decode_im(input logic [1:0] sel);
      logic [1:0] mode;
      if (sel[1] == 1'b0) begin
         mode = 2'd0;
      end else if (sel[0] == 1'b1) begin
         mode = 2'd2;
      end else begin
         mode = 2'd1;
      end
      return mode;
   endfunction

   state_t              state_r, state_next_s;
   logic [3:0]          wait_cnt_r, wait_cnt_next_s;
   logic                nmi_q_r, nmi_pending_r, ei_shadow_r;
   logic [1:0]          im_mode_r, mode_lat_r;
   logic                iff1_r, iff2_r;
   logic                take_irq_r, ack_req_r, vec_valid_r, busy_r;
   logic [1:0]          vec_kind_r;
   logic [ADDR_W-1:0]   vec_addr_r;
   logic [DATA_W-1:0]   opcode_r;

   logic                nmi_edge_s, nmi_any_s, int_ok_s;
   logic                accept_int_s, accept_nmi_s, capture_s;
   logic [1:0]          vec_kind_s;
   logic [ADDR_W-1:0]   vec_addr_s;
   logic                load_opcode_s;

   // An edge arriving in the boundary cycle itself counts as pending.
   assign nmi_edge_s = nmi_req & ~nmi_q_r;
   assign nmi_any_s  = nmi_pending_r | nmi_edge_s;
   assign int_ok_s   = int_req & iff1_r & ~ei_shadow_r;

   // FSM state and acknowledge wait counter register.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 4'd0;
      end else begin
         state_r    <= state_next_s;
         wait_cnt_r <= wait_cnt_next_s;
      end
   end

   // FSM next-state, acceptance and capture decisions.
   always_comb begin
      state_next_s    = state_r;
      wait_cnt_next_s = wait_cnt_r;
      accept_int_s    = 1'b0;
      accept_nmi_s    = 1'b0;
      capture_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (insn_end) begin
               if (nmi_any_s) begin
                  accept_nmi_s = 1'b1;
                  state_next_s = ST_NMI;
               end else if (int_ok_s) begin
                  accept_int_s    = 1'b1;
                  state_next_s    = ST_ACK;
                  wait_cnt_next_s = ACK_WAIT_C;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACK: begin
            // ack_ready is only honoured once the minimum hold has elapsed.
            if (wait_cnt_r != 4'd0) begin
               wait_cnt_next_s = wait_cnt_r - 4'd1;
            end else if (ack_ready) begin
               capture_s    = 1'b1;
               state_next_s = ST_VEC;
            end else begin
               state_next_s = ST_ACK;
            end
         end
         ST_VEC:  state_next_s = ST_IDLE;
         ST_NMI:  state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Vector resolution from the mode latched at acceptance.
   always_comb begin
      vec_kind_s    = 2'd0;
      vec_addr_s    = {ADDR_W{1'b0}};
      load_opcode_s = 1'b0;
      case (mode_lat_r)
         2'd0: begin
            vec_kind_s    = 2'd2;
            vec_addr_s    = {ADDR_W{1'b0}};
            load_opcode_s = 1'b1;
         end
         2'd1: begin
            vec_kind_s = 2'd0;
            vec_addr_s = IM1_VECTOR;
         end
         2'd2: begin
            vec_kind_s = 2'd1;
            if (IM2_ALIGN) begin
               vec_addr_s = {i_reg, data_in[DATA_W-1:1], 1'b0};
            end else begin
               vec_addr_s = {i_reg, data_in};
            end
         end
         default: begin
            vec_kind_s = 2'd0;
            vec_addr_s = IM1_VECTOR;
         end
      endcase
   end

   // Registered handshake and vector outputs.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         take_irq_r  <= 1'b0;
         ack_req_r   <= 1'b0;
         vec_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         vec_kind_r  <= 2'd0;
         vec_addr_r  <= {ADDR_W{1'b0}};
         opcode_r    <= {DATA_W{1'b0}};
      end else begin
         take_irq_r  <= accept_int_s | accept_nmi_s;
         ack_req_r   <= (state_next_s == ST_ACK);
         vec_valid_r <= capture_s | accept_nmi_s;
         busy_r      <= (state_next_s != ST_IDLE);
         if (accept_nmi_s) begin
            vec_kind_r <= 2'd0;
            vec_addr_r <= NMI_VECTOR;
         end else if (capture_s) begin
            vec_kind_r <= vec_kind_s;
            vec_addr_r <= vec_addr_s;
            if (load_opcode_s) begin
               opcode_r <= data_in;
            end
         end
      end
   end

   // Interrupt enable flags and EI shadow.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         iff1_r      <= 1'b0;
         iff2_r      <= 1'b0;
         ei_shadow_r <= 1'b0;
      end else begin
         if (accept_int_s) begin
            iff1_r <= 1'b0;
            iff2_r <= 1'b0;
         end else if (accept_nmi_s) begin
            iff1_r <= 1'b0;
         end else if (di) begin
            iff1_r <= 1'b0;
            iff2_r <= 1'b0;
         end else if (ei) begin
            iff1_r <= 1'b1;
            iff2_r <= 1'b1;
         end else if (retn) begin
            iff1_r <= iff2_r;
         end
         // Shadow covers exactly the first boundary after EI.
         if (di) begin
            ei_shadow_r <= 1'b0;
         end else if (ei) begin
            ei_shadow_r <= 1'b1;
         end else if (insn_end) begin
            ei_shadow_r <= 1'b0;
         end
      end
   end

   // NMI edge detector and pending latch; edge register resets high so a
   // request held through reset does not fire.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         nmi_q_r       <= 1'b1;
         nmi_pending_r <= 1'b0;
      end else begin
         nmi_q_r <= nmi_req;
         if (accept_nmi_s) begin
            nmi_pending_r <= 1'b0;
         end else if (nmi_edge_s) begin
            nmi_pending_r <= 1'b1;
         end
      end
   end

   // Interrupt mode register and the copy frozen for the current acknowledge.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         im_mode_r  <= 2'd0;
         mode_lat_r <= 2'd0;
      end else begin
         if (im_set) begin
            im_mode_r <= decode_im(im_sel);
         end
         if (accept_int_s) begin
            mode_lat_r <= im_mode_r;
         end
      end
   end

   assign take_irq   = take_irq_r;
   assign ack_req    = ack_req_r;
   assign vec_valid  = vec_valid_r;
   assign vec_kind   = vec_kind_r;
   assign vec_addr   = vec_addr_r;
   assign opcode_out = opcode_r;
   assign im_mode    = im_mode_r;
   assign iff1       = iff1_r;
   assign iff2       = iff2_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_interrupt_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_mode_controller
//
// Directed bench for interrupt_mode_controller (default parameters:
// ACK_WAIT=2, IM2_ALIGN=0). Inputs change and outputs are sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_interrupt_mode_controller;

   logic        clk;
   logic        notReset;
   logic        im_set;
   logic [1:0]  im_sel;
   logic        ei, di, retn, insn_end, int_req, nmi_req, ack_ready;
   logic [7:0]  data_in, i_reg;
   logic        take_irq, ack_req, vec_valid;
   logic [1:0]  vec_kind;
   logic [15:0] vec_addr;
   logic [7:0]  opcode_out;
   logic [1:0]  im_mode;
   logic        iff1, iff2, busy;

   int checks_cnt;
   int errors_cnt;
   int ack_cycles;
   int lat;
   int takes;

   interrupt_mode_controller dut (
      .clk        (clk),
      .notReset   (notReset),
      .im_set     (im_set),
      .im_sel     (im_sel),
      .ei         (ei),
      .di         (di),
      .retn       (retn),
      .insn_end   (insn_end),
      .int_req    (int_req),
      .nmi_req    (nmi_req),
      .ack_ready  (ack_ready),
      .data_in    (data_in),
      .i_reg      (i_reg),
      .take_irq   (take_irq),
      .ack_req    (ack_req),
      .vec_valid  (vec_valid),
      .vec_kind   (vec_kind),
      .vec_addr   (vec_addr),
      .opcode_out (opcode_out),
      .im_mode    (im_mode),
      .iff1       (iff1),
      .iff2       (iff2),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it disagrees.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From the take_irq cycle, run until vec_valid, counting ack_req cycles.
   task automatic wait_vec(output int acks, output int n);
      acks = 0;
      n    = 0;
      while (vec_valid !== 1'b1 && n < 20) begin
         if (ack_req === 1'b1) acks++;
         tick();
         n++;
      end
      if (vec_valid !== 1'b1) check("vec_timeout", {31'd0, vec_valid}, 32'd1);
   endtask

   // ei, then two boundaries with int_req high; leaves the bench at take cycle.
   task automatic ei_and_take(output logic first_take);
      int_req  = 1'b1;
      ei       = 1'b1;
      tick();
      ei       = 1'b0;
      insn_end = 1'b1;
      tick();
      first_take = take_irq;
      tick();
      insn_end = 1'b0;
   endtask

   logic early;

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      notReset = 1'b0; im_set = 1'b0; im_sel = 2'b00; ei = 1'b0; di = 1'b0;
      retn = 1'b0; insn_end = 1'b0; int_req = 1'b0; nmi_req = 1'b1;
      ack_ready = 1'b0; data_in = 8'h00; i_reg = 8'h80;

      // Reset state, NMI held high across reset release.
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_iff1", {31'd0, iff1}, 32'd0);
      check("rst_mode", {30'd0, im_mode}, 32'd0);
      check("rst_addr", {16'd0, vec_addr}, 32'd0);
      @(negedge clk);
      notReset = 1'b1;
      insn_end = 1'b1;
      tick();
      insn_end = 1'b0;
      check("nmi_held_take", {31'd0, take_irq}, 32'd0);
      check("nmi_held_busy", {31'd0, busy}, 32'd0);
      nmi_req = 1'b0;
      tick();

      // IM2 with EI shadow.
      im_set = 1'b1; im_sel = 2'b11;
      tick();
      im_set = 1'b0;
      check("im2_mode", {30'd0, im_mode}, 32'd2);
      ack_ready = 1'b1; data_in = 8'hE4;
      ei_and_take(early);
      check("shadow_take", {31'd0, early}, 32'd0);
      check("im2_take", {31'd0, take_irq}, 32'd1);
      check("im2_iff1", {31'd0, iff1}, 32'd0);
      check("im2_iff2", {31'd0, iff2}, 32'd0);
      wait_vec(ack_cycles, lat);
      check("im2_ack_cycles", ack_cycles, 32'd3);
      check("im2_kind", {30'd0, vec_kind}, 32'd1);
      check("im2_addr", {16'd0, vec_addr}, 32'h80E4);
      tick();
      check("im2_vv_pulse", {31'd0, vec_valid}, 32'd0);
      check("im2_hold", {16'd0, vec_addr}, 32'h80E4);

      // IM1, ack_ready high early must not shorten the wait.
      im_set = 1'b1; im_sel = 2'b10;
      tick();
      im_set = 1'b0;
      check("im1_mode", {30'd0, im_mode}, 32'd1);
      data_in = 8'h55;
      ei_and_take(early);
      check("im1_take", {31'd0, take_irq}, 32'd1);
      wait_vec(ack_cycles, lat);
      check("im1_latency", lat, 32'd3);
      check("im1_kind", {30'd0, vec_kind}, 32'd0);
      check("im1_addr", {16'd0, vec_addr}, 32'h0038);
      tick();

      // IM0 (field 01), im_set during ACK must not alter this acknowledge.
      im_set = 1'b1; im_sel = 2'b01;
      tick();
      im_set = 1'b0;
      check("im0_mode", {30'd0, im_mode}, 32'd0);
      data_in = 8'hFF;
      ei_and_take(early);
      im_set = 1'b1; im_sel = 2'b11;
      tick();
      im_set = 1'b0;
      wait_vec(ack_cycles, lat);
      check("im0_kind", {30'd0, vec_kind}, 32'd2);
      check("im0_opcode", {24'd0, opcode_out}, 32'h00FF);
      check("im0_addr", {16'd0, vec_addr}, 32'd0);
      check("im_set_in_ack", {30'd0, im_mode}, 32'd2);
      tick();

      // NMI beats INT at the same boundary.
      ei = 1'b1;
      tick();
      ei = 1'b0;
      insn_end = 1'b1;
      tick();
      nmi_req = 1'b1;
      tick();
      insn_end = 1'b0;
      check("nmi_take", {31'd0, take_irq}, 32'd1);
      check("nmi_vv", {31'd0, vec_valid}, 32'd1);
      check("nmi_addr", {16'd0, vec_addr}, 32'h0066);
      check("nmi_kind", {30'd0, vec_kind}, 32'd0);
      check("nmi_ack_req", {31'd0, ack_req}, 32'd0);
      check("nmi_iff1", {31'd0, iff1}, 32'd0);
      check("nmi_iff2", {31'd0, iff2}, 32'd1);
      tick();
      check("nmi_done", {31'd0, busy}, 32'd0);
      retn = 1'b1;
      tick();
      retn = 1'b0;
      check("retn_iff1", {31'd0, iff1}, 32'd1);
      insn_end = 1'b1;
      tick();
      insn_end = 1'b0;
      check("int_after_retn", {31'd0, ack_req}, 32'd1);
      // NMI edge during ACK is pended.
      nmi_req = 1'b0; ack_ready = 1'b0; data_in = 8'h12;
      tick();
      nmi_req = 1'b1; ack_ready = 1'b1;
      tick();
      wait_vec(ack_cycles, lat);
      check("int_vec_addr", {16'd0, vec_addr}, 32'h8012);
      tick();
      insn_end = 1'b1;
      tick();
      insn_end = 1'b0;
      check("pended_nmi_take", {31'd0, take_irq}, 32'd1);
      check("pended_nmi_addr", {16'd0, vec_addr}, 32'h0066);
      tick();

      // ei and di together, then INT masked for 10 boundaries.
      ei = 1'b1;
      tick();
      ei = 1'b1; di = 1'b1;
      tick();
      ei = 1'b0; di = 1'b0;
      check("eidi_iff1", {31'd0, iff1}, 32'd0);
      check("eidi_iff2", {31'd0, iff2}, 32'd0);
      takes = 0;
      insn_end = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (take_irq === 1'b1) takes++;
      end
      insn_end = 1'b0;
      check("masked_takes", takes, 32'd0);

      // Reset during ACK.
      ei_and_take(early);
      check("rst_ack_setup", {31'd0, ack_req}, 32'd1);
      #2;
      notReset = 1'b0;
      #1;
      check("rst_ack_req", {31'd0, ack_req}, 32'd0);
      check("rst_ack_busy", {31'd0, busy}, 32'd0);
      check("rst_ack_mode", {30'd0, im_mode}, 32'd0);
      @(negedge clk);
      notReset = 1'b1;
      takes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (vec_valid === 1'b1) takes++;
      end
      check("rst_no_vec", takes, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/interrupt_mode_controller.md
Name: interrupt_mode_controller

Overview:
- Sequential successor to the combinational IM 0/1/2 decode slice.
- Holds the interrupt mode register and the IFF1/IFF2 enable flip-flops, with the EI shadow delay.
- Edge-detects and prioritises NMI, and arbitrates INT at instruction boundaries.
- Runs the interrupt-acknowledge handshake and emits a resolved vector (IM0 opcode, IM1 restart, IM2 table pointer, NMI restart) to the sequencer.

Parameters:
DATA_W, 8, data bus and I-register width
ADDR_W, 16, vector address width; must equal 2*DATA_W
IM1_VECTOR, 16'h0038, IM1 restart address
NMI_VECTOR, 16'h0066, NMI restart address
ACK_WAIT, 2, minimum cycles ack_req is held before ack_ready is honoured (0..15)
IM2_ALIGN, 0, 1 forces IM2 vector LSB to 0

Ports:
clk  in  1  clock, all state on rising edge
notReset  in  1  asynchronous active-low reset
im_set  in  1  one-cycle strobe: decoded IM instruction
im_sel  in  2  opcode field Source[4:3]: 0x->IM0, 10->IM1, 11->IM2
ei  in  1  EI strobe
di  in  1  DI strobe
retn  in  1  RETN strobe (IFF1<=IFF2)
insn_end  in  1  instruction-boundary strobe; only point where interrupts are accepted
int_req  in  1  maskable request, level
nmi_req  in  1  non-maskable request, rising-edge sensitive
ack_ready  in  1  bus indicates data_in valid during acknowledge
data_in  in  DATA_W  acknowledge data from the interrupting device
i_reg  in  DATA_W  I register
take_irq  out  1  one-cycle pulse: next fetch is replaced by the interrupt sequence
ack_req  out  1  acknowledge cycle active
vec_valid  out  1  one-cycle pulse: vec_* and opcode_out valid
vec_kind  out  2  0 jump to vec_addr; 1 indirect via table at vec_addr; 2 execute opcode_out
vec_addr  out  ADDR_W  resolved address
opcode_out  out  DATA_W  IM0 opcode captured from data_in
im_mode  out  2  current mode: 0, 1 or 2
iff1  out  1  interrupt enable
iff2  out  1  IFF1 save copy
busy  out  1  state != IDLE

Behaviour:
- Reset (async, notReset=0): state IDLE; im_mode=0; iff1=iff2=0; nmi_pending=0; ei_shadow=0; wait counter 0; nmi edge register=1 (an NMI held high through reset does not fire); all outputs 0.
- Reset asserted mid-ACK drops ack_req immediately; no vec_valid.
- im_set: im_mode <= (im_sel[1]==0)?0 : (im_sel[0]?2:1) on the next edge. Independent of the FSM.
- Enable-flag priority in one cycle: acceptance > di > ei > retn.
  - di: iff1=iff2=0, ei_shadow=0.
  - ei: iff1=iff2=1, ei_shadow=1.
  - retn: iff1<=iff2.
  - Acceptance of INT clears iff1 and iff2.
  - Acceptance of NMI clears iff1 only.
- ei_shadow blocks INT at the first insn_end after ei, then clears at that insn_end. INT is therefore first accepted at the second boundary.
- NMI: rising edge of nmi_req sets nmi_pending. Pending is held until serviced; further edges while pending are merged. NMI is not masked by iff1 or ei_shadow.
- FSM states: IDLE, ACK, VEC, NMI.
  - IDLE + insn_end:
    - if nmi_pending -> NMI, take_irq=1, pending cleared;
    - else if int_req & iff1 & !ei_shadow -> ACK, take_irq=1, counter loaded with ACK_WAIT;
    - else stay.
  - insn_end outside IDLE is ignored.
  - ACK: ack_req=1. The counter decrements to 0. ack_ready is ignored while counter != 0. With counter==0 and ack_ready=1, data_in is captured -> VEC.
  - VEC: one cycle, vec_valid=1, then IDLE. Outputs by im_mode (latched at acceptance; im_set during ACK does not affect the current acknowledge):
    - IM0: kind=2, opcode_out=data_in, vec_addr=0.
    - IM1: kind=0, vec_addr=IM1_VECTOR, data ignored.
    - IM2: kind=1, vec_addr={i_reg, data_in}, LSB forced 0 if IM2_ALIGN.
  - NMI: one cycle, vec_valid=1, kind=0, vec_addr=NMI_VECTOR, ack_req stays 0, then IDLE.
- NMI edge arriving during ACK/VEC is pended and serviced at the next IDLE insn_end.
- int_req deasserting during ACK does not abort the acknowledge.
- vec_addr, vec_kind and opcode_out hold their last value between pulses.

Test Plan:
- Reset then im_set im_sel=2'b11, ei, two insn_end with int_req=1, ACK_WAIT=2, data_in=8'hE4 at first legal cycle, i_reg=8'h80 -> no take_irq at first insn_end; take_irq at second; ack_req high 3 cycles; vec_valid kind=1 vec_addr=16'h80E4; iff1=iff2=0.
- IM1 mode, iff1=1, int_req=1, insn_end -> vec_valid kind=0 vec_addr=16'h0038 ACK_WAIT+1 cycles after take_irq; ack_ready asserted early (counter!=0) has no effect.
- IM0, data_in=8'hFF -> kind=2 opcode_out=8'hFF vec_addr=0.
- nmi_req rising edge and int_req together at insn_end with iff1=iff2=1 -> NMI path, vec_addr=16'h0066, iff1=0 iff2=1; retn then restores iff1=1; a pending INT is taken at the following boundary.
- ei and di same cycle -> iff1=iff2=0; int_req held with iff1=0 -> no take_irq for 10 boundaries; nmi_req held high across reset release -> no NMI.
- notReset pulsed low during ACK -> ack_req=0 asynchronously, state IDLE, im_mode=0, no vec_valid afterwards.
